// File: rtl/multi_port_mem_arbiter.sv
`timescale 1ns/1ps
// multi_port_mem_arbiter
//
// Merges NUM_MASTERS independent bus masters (instruction prefetch, data
// load/store, DMA, debug, ...) onto one shared memory/IO port. Arbitration
// is fixed priority (master 0 highest) or round-robin, chosen by ROUND_ROBIN.
// A master holding m_lock through its ack keeps the bus (LOCKED) so atomic
// sequences are not interleaved with other masters.
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   m_addr/m_data_out/m_access/m_wr_en/m_bytesel/m_io/m_lock
//                       packed per-master request buses, master i at slice i
//   m_ack               per-master acknowledge (combinational from q_m_ack)
//   m_data_in           read data, broadcast to every master
//   q_m_*, q_io         shared memory port
//   grant, grant_valid  current owner index and its qualifier, for trace
module multi_port_mem_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_WIDTH  = 19,
  parameter int DATA_WIDTH  = 16,
  parameter int ROUND_ROBIN = 0,
  localparam int BS = DATA_WIDTH / 8,
  localparam int GW = $clog2(NUM_MASTERS)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_data_out,
  output logic [DATA_WIDTH-1:0]         m_data_in,
  input  logic [NUM_MASTERS-1:0]        m_access,
  output logic [NUM_MASTERS-1:0]        m_ack,
  input  logic [NUM_MASTERS-1:0]        m_wr_en,
  input  logic [NUM_MASTERS*BS-1:0]     m_bytesel,
  input  logic [NUM_MASTERS-1:0]        m_io,
  input  logic [NUM_MASTERS-1:0]        m_lock,
  output logic [ADDR_WIDTH:1]           q_m_addr,
  output logic [DATA_WIDTH-1:0]         q_m_data_out,
  input  logic [DATA_WIDTH-1:0]         q_m_data_in,
  output logic                          q_m_access,
  input  logic                          q_m_ack,
  output logic                          q_m_wr_en,
  output logic [BS-1:0]                 q_m_bytesel,
  output logic                          q_io,
  output logic [GW-1:0]                 grant,
  output logic                          grant_valid
);

  if (NUM_MASTERS < 2 || NUM_MASTERS > 8) begin : g_bad_num_masters
    $error("multi_port_mem_arbiter: NUM_MASTERS must be in 2..8");
  end
  if (DATA_WIDTH % 8 != 0) begin : g_bad_data_width
    $error("multi_port_mem_arbiter: DATA_WIDTH must be a multiple of 8");
  end

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_LOCKED} state_e;

  state_e          state_q, state_d;
  logic [GW-1:0]   grant_q, grant_d;
  logic [GW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [GW-1:0]   winner;
  logic [GW-1:0]   search_start;
  logic [GW-1:0]   grant_next;
  logic            found;
  logic            busy;

  logic [ADDR_WIDTH-1:0] addr_a  [NUM_MASTERS];
  logic [DATA_WIDTH-1:0] wdata_a [NUM_MASTERS];
  logic [BS-1:0]         bsel_a  [NUM_MASTERS];

  always_comb begin
    for (int i = 0; i < NUM_MASTERS; i++) begin
      addr_a[i]  = m_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      wdata_a[i] = m_data_out[i*DATA_WIDTH +: DATA_WIDTH];
      bsel_a[i]  = m_bytesel[i*BS +: BS];
    end
  end

  // Fixed priority is a round-robin search that always starts at master 0.
  assign search_start = (ROUND_ROBIN != 0) ? rr_ptr_q : '0;

  always_comb begin
    logic [GW:0]   idx_w;
    logic [GW-1:0] cand;
    winner = '0;
    found  = 1'b0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      idx_w = {1'b0, search_start} + (GW+1)'(k);
      if (idx_w >= (GW+1)'(NUM_MASTERS)) begin
        idx_w = idx_w - (GW+1)'(NUM_MASTERS);
      end
      cand = idx_w[GW-1:0];
      if (!found && m_access[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  assign grant_next = (grant_q == GW'(NUM_MASTERS - 1)) ? '0 : grant_q + GW'(1);

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          state_d = S_BUSY;
          grant_d = winner;
        end
      end
      S_BUSY: begin
        // Owner withdrew before the slave answered: abandon, fairness untouched.
        if (!m_access[grant_q]) begin
          state_d = S_IDLE;
        end else if (q_m_ack) begin
          state_d = m_lock[grant_q] ? S_LOCKED : S_IDLE;
          if (ROUND_ROBIN != 0) begin
            rr_ptr_d = grant_next;
          end
        end
      end
      S_LOCKED: begin
        if (m_access[grant_q]) begin
          state_d = S_BUSY;
        end else if (!m_lock[grant_q]) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // Shared-port drive comes straight from the state flop, so an asynchronous
  // reset drops the request and blocks any coincident ack immediately.
  assign busy = (state_q == S_BUSY);

  always_comb begin
    m_ack = '0;
    if (busy) begin
      m_ack[grant_q] = q_m_ack;
    end
  end

  assign q_m_access   = busy & m_access[grant_q];
  assign q_m_wr_en    = busy & m_wr_en[grant_q];
  assign q_io         = busy & m_io[grant_q];
  assign q_m_addr     = busy ? addr_a[grant_q]  : '0;
  assign q_m_data_out = busy ? wdata_a[grant_q] : '0;
  assign q_m_bytesel  = busy ? bsel_a[grant_q]  : '0;
  assign m_data_in    = q_m_data_in;
  assign grant        = grant_q;
  assign grant_valid  = (state_q != S_IDLE);

endmodule

// File: tb/tb_multi_port_mem_arbiter.sv
`timescale 1ns/1ps
module tb_multi_port_mem_arbiter;

  logic clk = 1'b0;
  logic reset;
  int   nvec = 0;
  int   nerr = 0;

  always #5 clk = ~clk;

  // f_: N=2 fixed priority, default widths
  logic [37:0] f_addr;  logic [31:0] f_dout; logic [15:0] f_din;
  logic [1:0]  f_acc, f_ack, f_wr, f_io, f_lock; logic [3:0] f_bs;
  logic [19:1] f_qaddr; logic [15:0] f_qdout, f_qdin;
  logic        f_qacc, f_qack, f_qwr, f_qio, f_gv; logic [1:0] f_qbs;
  logic [0:0]  f_grant;
  // r_: N=4 round robin
  logic [75:0] r_addr;  logic [63:0] r_dout; logic [15:0] r_din;
  logic [3:0]  r_acc, r_ack, r_wr, r_io, r_lock; logic [7:0] r_bs;
  logic [19:1] r_qaddr; logic [15:0] r_qdout, r_qdin;
  logic        r_qacc, r_qack, r_qwr, r_qio, r_gv; logic [1:0] r_qbs;
  logic [1:0]  r_grant;
  // l_: N=3 fixed priority, lock scenarios
  logic [56:0] l_addr;  logic [47:0] l_dout; logic [15:0] l_din;
  logic [2:0]  l_acc, l_ack, l_wr, l_io, l_lock; logic [5:0] l_bs;
  logic [19:1] l_qaddr; logic [15:0] l_qdout, l_qdin;
  logic        l_qacc, l_qack, l_qwr, l_qio, l_gv; logic [1:0] l_qbs;
  logic [1:0]  l_grant;
  // w_: N=2, 32-bit data, 22-bit address
  logic [43:0] w_addr;  logic [63:0] w_dout; logic [31:0] w_din;
  logic [1:0]  w_acc, w_ack, w_wr, w_io, w_lock; logic [7:0] w_bs;
  logic [22:1] w_qaddr; logic [31:0] w_qdout, w_qdin;
  logic        w_qacc, w_qack, w_qwr, w_qio, w_gv; logic [3:0] w_qbs;
  logic [0:0]  w_grant;

  logic [4:0] f_st, w_st;
  logic [7:0] r_st;
  logic [6:0] l_st;
  assign f_st = {f_qacc, f_gv, f_grant, f_ack};
  assign r_st = {r_qacc, r_gv, r_grant, r_ack};
  assign l_st = {l_qacc, l_gv, l_grant, l_ack};
  assign w_st = {w_qacc, w_gv, w_grant, w_ack};

  multi_port_mem_arbiter #(.NUM_MASTERS(2), .ADDR_WIDTH(19), .DATA_WIDTH(16), .ROUND_ROBIN(0)) u_fp (
    .clk(clk), .reset(reset), .m_addr(f_addr), .m_data_out(f_dout), .m_data_in(f_din),
    .m_access(f_acc), .m_ack(f_ack), .m_wr_en(f_wr), .m_bytesel(f_bs), .m_io(f_io),
    .m_lock(f_lock), .q_m_addr(f_qaddr), .q_m_data_out(f_qdout), .q_m_data_in(f_qdin),
    .q_m_access(f_qacc), .q_m_ack(f_qack), .q_m_wr_en(f_qwr), .q_m_bytesel(f_qbs),
    .q_io(f_qio), .grant(f_grant), .grant_valid(f_gv));

  multi_port_mem_arbiter #(.NUM_MASTERS(4), .ADDR_WIDTH(19), .DATA_WIDTH(16), .ROUND_ROBIN(1)) u_rr (
    .clk(clk), .reset(reset), .m_addr(r_addr), .m_data_out(r_dout), .m_data_in(r_din),
    .m_access(r_acc), .m_ack(r_ack), .m_wr_en(r_wr), .m_bytesel(r_bs), .m_io(r_io),
    .m_lock(r_lock), .q_m_addr(r_qaddr), .q_m_data_out(r_qdout), .q_m_data_in(r_qdin),
    .q_m_access(r_qacc), .q_m_ack(r_qack), .q_m_wr_en(r_qwr), .q_m_bytesel(r_qbs),
    .q_io(r_qio), .grant(r_grant), .grant_valid(r_gv));

  multi_port_mem_arbiter #(.NUM_MASTERS(3), .ADDR_WIDTH(19), .DATA_WIDTH(16), .ROUND_ROBIN(0)) u_lk (
    .clk(clk), .reset(reset), .m_addr(l_addr), .m_data_out(l_dout), .m_data_in(l_din),
    .m_access(l_acc), .m_ack(l_ack), .m_wr_en(l_wr), .m_bytesel(l_bs), .m_io(l_io),
    .m_lock(l_lock), .q_m_addr(l_qaddr), .q_m_data_out(l_qdout), .q_m_data_in(l_qdin),
    .q_m_access(l_qacc), .q_m_ack(l_qack), .q_m_wr_en(l_qwr), .q_m_bytesel(l_qbs),
    .q_io(l_qio), .grant(l_grant), .grant_valid(l_gv));

  multi_port_mem_arbiter #(.NUM_MASTERS(2), .ADDR_WIDTH(22), .DATA_WIDTH(32), .ROUND_ROBIN(0)) u_wd (
    .clk(clk), .reset(reset), .m_addr(w_addr), .m_data_out(w_dout), .m_data_in(w_din),
    .m_access(w_acc), .m_ack(w_ack), .m_wr_en(w_wr), .m_bytesel(w_bs), .m_io(w_io),
    .m_lock(w_lock), .q_m_addr(w_qaddr), .q_m_data_out(w_qdout), .q_m_data_in(w_qdin),
    .q_m_access(w_qacc), .q_m_ack(w_qack), .q_m_wr_en(w_qwr), .q_m_bytesel(w_qbs),
    .q_io(w_qio), .grant(w_grant), .grant_valid(w_gv));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    nvec++; if (f_st !== 5'b0) begin nerr++; $display("FAIL reset_fp: got %b exp %b", f_st, 5'b0); end
    nvec++; if (r_st !== 8'b0) begin nerr++; $display("FAIL reset_rr: got %b exp %b", r_st, 8'b0); end
    nvec++; if (l_st !== 7'b0) begin nerr++; $display("FAIL reset_lk: got %b exp %b", l_st, 7'b0); end
    nvec++; if (w_st !== 5'b0) begin nerr++; $display("FAIL reset_wd: got %b exp %b", w_st, 5'b0); end
    reset = 1'b0;
    #1;
  endtask

  task automatic test_fixed_priority();
    f_acc = 2'b11; f_qack = 1'b0;
    #1;
    nvec++; if (f_st !== 5'b00000) begin nerr++; $display("FAIL fp_idle: got %b exp %b", f_st, 5'b00000); end
    tick();
    nvec++; if (f_st !== 5'b11000) begin nerr++; $display("FAIL fp_m0_grant: got %b exp %b", f_st, 5'b11000); end
    tick();
    nvec++; if (f_st !== 5'b11000) begin nerr++; $display("FAIL fp_m0_wait: got %b exp %b", f_st, 5'b11000); end
    f_qack = 1'b1;
    #1;
    nvec++; if (f_st !== 5'b11001) begin nerr++; $display("FAIL fp_m0_ack: got %b exp %b", f_st, 5'b11001); end
    tick();
    f_acc = 2'b10; f_qack = 1'b0;
    #1;
    nvec++; if (f_st !== 5'b00000) begin nerr++; $display("FAIL fp_turnaround: got %b exp %b", f_st, 5'b00000); end
    tick();
    nvec++; if (f_st !== 5'b11100) begin nerr++; $display("FAIL fp_m1_grant: got %b exp %b", f_st, 5'b11100); end
    f_qack = 1'b1;
    #1;
    nvec++; if (f_st !== 5'b11110) begin nerr++; $display("FAIL fp_m1_ack: got %b exp %b", f_st, 5'b11110); end
    tick();
    f_acc = 2'b00; f_qack = 1'b0;
    #1;
    nvec++; if (f_st !== 5'b00100) begin nerr++; $display("FAIL fp_done: got %b exp %b", f_st, 5'b00100); end
  endtask

  task automatic test_mux();
    logic [39:0] port;
    f_addr = {19'h7FFFF, 19'h12345};
    f_dout = {16'hA55A, 16'h1234};
    f_bs   = {2'b10, 2'b11};
    f_wr   = 2'b11; f_io = 2'b11; f_qdin = 16'h5AA5; f_acc = 2'b00;
    #1;
    port = {f_qaddr, f_qdout, f_qbs, f_qwr, f_qio};
    nvec++; if (port !== 40'h0) begin nerr++; $display("FAIL mux_idle_zero: got %h exp %h", port, 40'h0); end
    nvec++; if (f_din !== 16'h5AA5) begin nerr++; $display("FAIL mux_din_idle: got %h exp %h", f_din, 16'h5AA5); end
    f_acc = 2'b10;
    tick();
    port = {f_qaddr, f_qdout, f_qbs, f_qwr, f_qio};
    nvec++; if (port !== {19'h7FFFF, 16'hA55A, 2'b10, 1'b1, 1'b1}) begin
      nerr++; $display("FAIL mux_busy: got %h exp %h", port, {19'h7FFFF, 16'hA55A, 2'b10, 1'b1, 1'b1});
    end
    f_qdin = 16'hC33C;
    #1;
    nvec++; if (f_din !== 16'hC33C) begin nerr++; $display("FAIL mux_din_busy: got %h exp %h", f_din, 16'hC33C); end
    f_qack = 1'b1;
    tick();
    f_acc = 2'b00; f_qack = 1'b0;
    #1;
    port = {f_qaddr, f_qdout, f_qbs, f_qwr, f_qio};
    nvec++; if (port !== 40'h0) begin nerr++; $display("FAIL mux_after_zero: got %h exp %h", port, 40'h0); end
  endtask

  task automatic test_round_robin();
    int g [5] = '{0, 1, 2, 3, 0};
    logic [1:0] eg;
    logic [3:0] ea;
    r_acc = 4'b1111; r_qack = 1'b0;
    for (int i = 0; i < 5; i++) begin
      eg = 2'(g[i]);
      ea = 4'b0001 << g[i];
      tick();
      nvec++; if (r_st[7:4] !== {2'b11, eg}) begin nerr++; $display("FAIL rr_grant%0d: got %b exp %b", i, r_st[7:4], {2'b11, eg}); end
      r_qack = 1'b1;
      #1;
      nvec++; if (r_ack !== ea) begin nerr++; $display("FAIL rr_ack%0d: got %b exp %b", i, r_ack, ea); end
      tick();
      r_qack = 1'b0;
      if (i == 4) r_acc = 4'b0000;
      #1;
      nvec++; if (r_st !== {2'b00, eg, 4'b0000}) begin nerr++; $display("FAIL rr_idle%0d: got %b exp %b", i, r_st, {2'b00, eg, 4'b0000}); end
    end
  endtask

  task automatic test_abandon_reset();
    // rr_ptr is 1 after the round-robin sequence ended on master 0.
    r_acc = 4'b0100;
    tick();
    nvec++; if (r_st[7:4] !== 4'b1110) begin nerr++; $display("FAIL ab_grant2: got %b exp %b", r_st[7:4], 4'b1110); end
    r_acc = 4'b0000;
    #1;
    nvec++; if (r_st !== 8'b01100000) begin nerr++; $display("FAIL ab_drop: got %b exp %b", r_st, 8'b01100000); end
    tick();
    nvec++; if (r_st !== 8'b00100000) begin nerr++; $display("FAIL ab_idle: got %b exp %b", r_st, 8'b00100000); end
    r_acc = 4'b0101;
    tick();
    nvec++; if (r_st[7:4] !== 4'b1110) begin nerr++; $display("FAIL ab_ptr_kept: got %b exp %b", r_st[7:4], 4'b1110); end
    r_qack = 1'b1;
    #1;
    reset = 1'b1;
    #1;
    nvec++; if (r_st !== 8'b0) begin nerr++; $display("FAIL rst_async: got %b exp %b", r_st, 8'b0); end
    @(posedge clk);
    #1;
    reset = 1'b0; r_acc = 4'b0000; r_qack = 1'b0;
    #1;
    nvec++; if (r_st !== 8'b0) begin nerr++; $display("FAIL rst_after: got %b exp %b", r_st, 8'b0); end
    r_acc = 4'b0101;
    tick();
    nvec++; if (r_st[7:4] !== 4'b1100) begin nerr++; $display("FAIL rst_ptr_clear: got %b exp %b", r_st[7:4], 4'b1100); end
    r_qack = 1'b1;
    tick();
    r_acc = 4'b0000; r_qack = 1'b0;
    #1;
  endtask

  task automatic test_lock();
    l_acc = 3'b100; l_lock = 3'b100; l_qack = 1'b0;
    tick();
    l_acc = 3'b101;
    for (int k = 0; k < 3; k++) begin
      #1;
      nvec++; if (l_st[6:3] !== 4'b1110) begin nerr++; $display("FAIL lk_busy%0d: got %b exp %b", k, l_st[6:3], 4'b1110); end
      l_qack = 1'b1;
      #1;
      nvec++; if (l_ack !== 3'b100) begin nerr++; $display("FAIL lk_ack%0d: got %b exp %b", k, l_ack, 3'b100); end
      tick();
      l_qack = 1'b0;
      #1;
      nvec++; if (l_st !== 7'b0110000) begin nerr++; $display("FAIL lk_locked%0d: got %b exp %b", k, l_st, 7'b0110000); end
      if (k < 2) tick();
    end
    l_acc = 3'b001;
    tick();
    nvec++; if (l_st !== 7'b0110000) begin nerr++; $display("FAIL lk_starve: got %b exp %b", l_st, 7'b0110000); end
    l_lock = 3'b000;
    tick();
    nvec++; if (l_st !== 7'b0010000) begin nerr++; $display("FAIL lk_release: got %b exp %b", l_st, 7'b0010000); end
    tick();
    nvec++; if (l_st[6:3] !== 4'b1100) begin nerr++; $display("FAIL lk_m0_grant: got %b exp %b", l_st[6:3], 4'b1100); end
    l_qack = 1'b1;
    #1;
    nvec++; if (l_ack !== 3'b001) begin nerr++; $display("FAIL lk_m0_ack: got %b exp %b", l_ack, 3'b001); end
    tick();
    l_acc = 3'b000; l_qack = 1'b0;
    #1;
  endtask

  task automatic test_width();
    logic [57:0] port;
    w_qdin = 32'hDEADBEEF;
    w_addr = {22'h3ABCDE, 22'h000000};
    w_dout = {32'hCAFEF00D, 32'h00000000};
    w_bs   = {4'b1010, 4'b0101};
    #1;
    nvec++; if (w_din !== 32'hDEADBEEF) begin nerr++; $display("FAIL wd_din_idle: got %h exp %h", w_din, 32'hDEADBEEF); end
    w_acc = 2'b10;
    tick();
    port = {w_qaddr, w_qdout, w_qbs};
    nvec++; if (port !== {22'h3ABCDE, 32'hCAFEF00D, 4'b1010}) begin
      nerr++; $display("FAIL wd_busy_port: got %h exp %h", port, {22'h3ABCDE, 32'hCAFEF00D, 4'b1010});
    end
    nvec++; if (w_din !== 32'hDEADBEEF) begin nerr++; $display("FAIL wd_din_busy: got %h exp %h", w_din, 32'hDEADBEEF); end
    w_qack = 1'b1;
    #1;
    nvec++; if (w_st !== 5'b11110) begin nerr++; $display("FAIL wd_ack: got %b exp %b", w_st, 5'b11110); end
    tick();
    w_acc = 2'b00; w_qack = 1'b0;
    #1;
  endtask

  initial begin
    reset = 1'b1;
    f_addr = '0; f_dout = '0; f_acc = '0; f_wr = '0; f_io = '0; f_lock = '0; f_bs = '0; f_qdin = '0; f_qack = 1'b0;
    r_addr = '0; r_dout = '0; r_acc = '0; r_wr = '0; r_io = '0; r_lock = '0; r_bs = '0; r_qdin = '0; r_qack = 1'b0;
    l_addr = '0; l_dout = '0; l_acc = '0; l_wr = '0; l_io = '0; l_lock = '0; l_bs = '0; l_qdin = '0; l_qack = 1'b0;
    w_addr = '0; w_dout = '0; w_acc = '0; w_wr = '0; w_io = '0; w_lock = '0; w_bs = '0; w_qdin = '0; w_qack = 1'b0;
    test_reset();
    test_fixed_priority();
    test_mux();
    test_round_robin();
    test_abandon_reset();
    test_lock();
    test_width();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
